// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory port, redirect request and the
// decode-facing valid/ready channel with fault status.
interface instr_fetch_unit_if;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        fetch_fault;
    logic [63:0] fault_pc;

    modport master (
        output imem_addr, out_valid, out_pc, out_instr, fetch_fault, fault_pc,
        input  imem_instr, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_addr, out_valid, out_pc, out_instr, fetch_fault, fault_pc,
        output imem_instr, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: drives the PC into a combinational instruction memory,
// buffers {pc, instr} pairs in a small FIFO, and supports redirect and sticky faults.
module instr_fetch_unit #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int          QDEPTH    = 2,
    parameter int          MEM_BYTES = 16384
) (
    input logic               clk,
    input logic               rst,
    instr_fetch_unit_if.master bus
);
    localparam int                PTR_W   = $clog2(QDEPTH);
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [63:0]       LAST_PC = 64'(MEM_BYTES) - 64'd4;
    localparam logic [CNT_W-1:0]  DEPTH   = CNT_W'(QDEPTH);

    typedef enum logic {RUN, FAULT} state_t;

    state_t            state, state_nxt;
    logic [63:0]       fetch_pc, fetch_pc_nxt;
    logic [CNT_W-1:0]  count, count_nxt;
    logic [PTR_W-1:0]  rd_ptr, rd_ptr_nxt;
    logic [PTR_W-1:0]  wr_ptr, wr_ptr_nxt;
    logic              fault, fault_nxt;
    logic [63:0]       fault_pc, fault_pc_nxt;

    logic [63:0]       pc_mem    [QDEPTH];
    logic [31:0]       instr_mem [QDEPTH];

    logic bad_pc;
    logic empty;
    logic push;
    logic pop;

    assign bad_pc = (fetch_pc[1:0] != 2'b00) || (fetch_pc > LAST_PC);
    assign empty  = (count == '0);
    assign pop    = bus.out_valid && bus.out_ready;
    // A push may use the slot freed by a same-cycle pop, so a full queue still streams.
    assign push   = (state == RUN) && !bus.redirect_valid && !bad_pc && ((count < DEPTH) || pop);

    assign bus.imem_addr   = fetch_pc;
    assign bus.out_valid   = !empty && !bus.redirect_valid;
    assign bus.out_pc      = empty ? '0 : pc_mem[rd_ptr];
    assign bus.out_instr   = empty ? '0 : instr_mem[rd_ptr];
    assign bus.fetch_fault = fault;
    assign bus.fault_pc    = fault_pc;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        count_nxt    = count;
        rd_ptr_nxt   = rd_ptr;
        wr_ptr_nxt   = wr_ptr;
        fault_nxt    = fault;
        fault_pc_nxt = fault_pc;

        if (bus.redirect_valid) begin
            state_nxt    = RUN;
            fetch_pc_nxt = bus.redirect_pc;
            count_nxt    = '0;
            rd_ptr_nxt   = '0;
            wr_ptr_nxt   = '0;
            fault_nxt    = 1'b0;
        end else begin
            if (pop)
                rd_ptr_nxt = rd_ptr + PTR_W'(1);
            if (push) begin
                wr_ptr_nxt   = wr_ptr + PTR_W'(1);
                fetch_pc_nxt = fetch_pc + 64'd4;
            end
            count_nxt = count + CNT_W'(push) - CNT_W'(pop);

            if (state == RUN && bad_pc) begin
                state_nxt    = FAULT;
                fault_nxt    = 1'b1;
                fault_pc_nxt = fetch_pc;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            fetch_pc <= RESET_PC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fault    <= 1'b0;
            fault_pc <= '0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            count    <= count_nxt;
            rd_ptr   <= rd_ptr_nxt;
            wr_ptr   <= wr_ptr_nxt;
            fault    <= fault_nxt;
            fault_pc <= fault_pc_nxt;
        end
    end

    // NOTE: queue storage is not reset; count gates every read, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= fetch_pc;
            instr_mem[wr_ptr] <= bus.imem_instr;
        end
    end
endmodule
